ita_output_writer: RTL
======================

ITA_OUTPUT_WRITER -- requirements
Module: ita_output_writer

Interface
REQ-001 SHALL have parameter N, default 16, output lanes per beat.
REQ-002 SHALL have parameter WI, default 8, bits per lane.
REQ-003 SHALL have parameter AW, default 32, memory address width.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  single-cycle job start; sampled only in Idle.
REQ-007 SHALL have port base_addr_i  input  AW  byte address of element (0,0); captured on start.
REQ-008 SHALL have port row_stride_i  input  AW  byte distance between rows; captured on start.
REQ-009 SHALL have port n_rows_i  input  16  rows per tile; captured on start.
REQ-010 SHALL have port n_tiles_i  input  16  column tiles per job; captured on start.
REQ-011 SHALL have port valid_i  input  1  ITA output beat valid.
REQ-012 SHALL have port ready_o  output  1  beat accepted when valid_i && ready_o.
REQ-013 SHALL have port data_i  input  N*WI  requantized output beat.
REQ-014 SHALL have port mem_req_o  output  1  write request, held until granted.
REQ-015 SHALL have port mem_gnt_i  input  1  request accepted this cycle.
REQ-016 SHALL have port mem_addr_o  output  AW  byte address of the write.
REQ-017 SHALL have port mem_wdata_o  output  N*WI  write data.
REQ-018 SHALL have port mem_we_o  output  1  constant 1 while mem_req_o is high, else 0.
REQ-019 SHALL have port busy_o  output  1  high in Run and Flush.
REQ-020 SHALL have port done_o  output  1  one-cycle pulse at job completion.

Function
REQ-021 SHALL implement FSM Idle -> Run (start_i) -> Flush (last beat accepted) -> Idle (last write granted), asserting done_o in the cycle Flush exits.
REQ-022 SHALL go from Idle directly to a one-cycle done_o pulse, without entering Run, when start_i arrives with n_rows_i == 0 or n_tiles_i == 0.
REQ-023 SHALL ignore start_i outside Idle.
REQ-024 SHALL drive ready_o = (state == Run) && (!mem_req_o || mem_gnt_i), giving a one-entry buffer with full throughput under continuous grant.
REQ-025 SHALL latch data_i and its computed address into the output register on an accepted beat and raise mem_req_o the next cycle.
REQ-026 SHALL keep mem_addr_o and mem_wdata_o stable while mem_req_o && !mem_gnt_i.
REQ-027 SHALL compute beat address = base + r*row_stride + t*(N*WI/8), with r iterating fastest (0..n_rows-1) and then t (0..n_tiles-1), in modulo-2^AW arithmetic.
REQ-028 SHALL wrap r to 0 and increment t on acceptance of row n_rows-1, and leave Run on acceptance of beat (n_rows-1, n_tiles-1).
REQ-029 SHALL generate addresses with running accumulators (row_addr += stride, tile_base += N*WI/8) and no multipliers.
REQ-030 SHALL not drop or duplicate beats: a grant and a new accept in the same cycle replace the register contents.
REQ-031 SHALL keep ready_o low in Flush even if valid_i stays high.

Reset
REQ-032 SHALL reset asynchronously to Idle with ready_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, and all counters 0.
REQ-033 SHALL abandon any in-flight request on reset mid-job, with no done_o pulse.

Structure
REQ-034 SHALL take N and WI defaults, the FSM state enum, and a writer counter type from ita_package.
REQ-035 SHALL place address generation in one sub-module, ita_output_addr_gen (counters r/t, accumulators, last flag).

Verification
REQ-036 SHALL cover this case: base=0x1000, stride=64, rows=2, tiles=2, N=16, grant always 1 -> addresses 0x1000, 0x1040, 0x1010, 0x1050; done_o once, 1 cycle after the 4th grant.
REQ-037 SHALL cover this case: grant low for 3 cycles on beat 0 -> mem_addr_o and mem_wdata_o stable, ready_o low for those 3 cycles, no beat lost.
REQ-038 SHALL cover this case: valid_i and mem_gnt_i random at 50% for rows=5, tiles=3 -> scoreboard sees 15 writes in order with correct data/address pairs.
REQ-039 SHALL cover this case: start with rows=0 -> done_o pulse the next cycle, no mem_req_o, busy_o stays 0.
REQ-040 SHALL cover this case: base=0xFFFF_FFF0, stride=0x20, rows=2, tiles=1 -> second address 0x0000_0010 (wrap).
REQ-041 SHALL cover this case: rst_ni low during Run with req pending -> all outputs 0 immediately, and a new job after release completes correctly.

Source files
------------

// File: rtl/ita_package.sv
// ITA shared types and defaults.
// Used by the output writer and its address generator.
package ita_package;

    localparam int unsigned ITA_N  = 16;
    localparam int unsigned ITA_WI = 8;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RUN,
        WR_FLUSH
    } writer_state_e;

    typedef logic [15:0] writer_cnt_t;

endpackage

// File: rtl/ita_output_addr_gen.sv
// ITA output writer address generator.
// Walks rows fastest, then column tiles, using adders only.
module ita_output_addr_gen
    import ita_package::*;
#(
    parameter int unsigned N  = ITA_N,
    parameter int unsigned WI = ITA_WI,
    parameter int unsigned AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW-1:0] row_stride_i,
    input  writer_cnt_t   n_rows_i,
    input  writer_cnt_t   n_tiles_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam logic [AW-1:0] TileBytes = AW'(N * WI / 8);

    writer_cnt_t   r_q;
    writer_cnt_t   t_q;
    writer_cnt_t   rows_q;
    writer_cnt_t   tiles_q;
    logic [AW-1:0] stride_q;
    logic [AW-1:0] tile_base_q;
    logic [AW-1:0] row_addr_q;
    logic          row_last;

    assign row_last = (r_q == rows_q - writer_cnt_t'(1));
    assign last_o   = row_last && (t_q == tiles_q - writer_cnt_t'(1));
    assign addr_o   = row_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q         <= '0;
            t_q         <= '0;
            rows_q      <= '0;
            tiles_q     <= '0;
            stride_q    <= '0;
            tile_base_q <= '0;
            row_addr_q  <= '0;
        end else if (load_i) begin
            r_q         <= '0;
            t_q         <= '0;
            rows_q      <= n_rows_i;
            tiles_q     <= n_tiles_i;
            stride_q    <= row_stride_i;
            tile_base_q <= base_addr_i;
            row_addr_q  <= base_addr_i;
        end else if (step_i) begin
            if (row_last) begin
                // next tile restarts at row 0 of the shifted column base
                r_q         <= '0;
                t_q         <= t_q + writer_cnt_t'(1);
                tile_base_q <= tile_base_q + TileBytes;
                row_addr_q  <= tile_base_q + TileBytes;
            end else begin
                r_q        <= r_q + writer_cnt_t'(1);
                row_addr_q <= row_addr_q + stride_q;
            end
        end
    end

endmodule

// File: rtl/ita_output_writer.sv
// ITA output writer: buffers output beats and writes them
// to memory as a row-major walk over column tiles.
module ita_output_writer
    import ita_package::*;
#(
    parameter int unsigned N  = ITA_N,
    parameter int unsigned WI = ITA_WI,
    parameter int unsigned AW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [AW-1:0]   base_addr_i,
    input  logic [AW-1:0]   row_stride_i,
    input  logic [15:0]     n_rows_i,
    input  logic [15:0]     n_tiles_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [N*WI-1:0] data_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic [N*WI-1:0] mem_wdata_o,
    output logic            mem_we_o,
    output logic            busy_o,
    output logic            done_o
);

    writer_state_e state_q;
    logic          empty_job;
    logic          load;
    logic          accept;
    logic [AW-1:0] gen_addr;
    logic          gen_last;

    assign empty_job = (n_rows_i == 16'd0) || (n_tiles_i == 16'd0);
    assign load      = (state_q == WR_IDLE) && start_i && !empty_job;
    assign ready_o   = (state_q == WR_RUN) && (!mem_req_o || mem_gnt_i);
    assign accept    = valid_i && ready_o;
    assign mem_we_o  = mem_req_o;
    assign busy_o    = (state_q != WR_IDLE);

    ita_output_addr_gen #(
        .N  (N),
        .WI (WI),
        .AW (AW)
    ) i_addr_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (load),
        .base_addr_i  (base_addr_i),
        .row_stride_i (row_stride_i),
        .n_rows_i     (n_rows_i),
        .n_tiles_i    (n_tiles_i),
        .step_i       (accept),
        .addr_o       (gen_addr),
        .last_o       (gen_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WR_IDLE;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                WR_IDLE: begin
                    if (start_i) begin
                        if (empty_job) begin
                            done_o <= 1'b1;
                        end else begin
                            state_q <= WR_RUN;
                        end
                    end
                end
                WR_RUN: begin
                    // a new accept overwrites a beat granted this cycle
                    if (accept) begin
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= gen_addr;
                        mem_wdata_o <= data_i;
                        if (gen_last) begin
                            state_q <= WR_FLUSH;
                        end
                    end else if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                    end
                end
                WR_FLUSH: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= WR_IDLE;
                        done_o    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WR_IDLE;
                end
            endcase
        end
    end

endmodule
